// File: rtl/pipe_add_sub.sv
// pipe_add_sub: pipelined adder/subtractor resolving CHUNK bits per stage, with a
// global valid/ready advance so the whole pipe either shifts or holds each cycle.
module pipe_add_sub #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in1_i,
    input  logic [WIDTH-1:0] in2_i,
    input  logic             c_in_i,
    input  logic             op_sub_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             c_out_o,
    output logic             ovf_o,
    output logic             zero_o
);
    localparam int STAGES = WIDTH / CHUNK;
    localparam int L = STAGES - 1;
    logic adv;
    logic [STAGES-1:0] v_q, v_d, c_q, c_d, pc;
    logic [STAGES-1:0][WIDTH-1:0] s_q, s_d, ps, pa, pb;
    logic [STAGES-1:0][CHUNK:0] sl;
    logic ovf_q, zero_q;

    assign adv = out_ready_i | ~v_q[L];
    assign in_ready_o = adv;
    assign pa[0] = in1_i;
    assign pb[0] = op_sub_i ? ~in2_i : in2_i;
    assign pc = STAGES'({c_q, c_in_i});
    assign v_d = STAGES'({v_q, in_valid_i});
    assign ps = s_q << WIDTH;

    // operands ride along with the beat; the last stage has no slice left to consume
    if (STAGES > 1) begin : g_ops
        logic [L-1:0][WIDTH-1:0] a_q, b_q;
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                a_q <= '0;
                b_q <= '0;
            end else if (adv) begin
                a_q <= pa[L-1:0];
                b_q <= pb[L-1:0];
            end
        end
        assign pa[L:1] = a_q;
        assign pb[L:1] = b_q;
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            sl[k] = {1'b0, pa[k][k*CHUNK +: CHUNK]} + {1'b0, pb[k][k*CHUNK +: CHUNK]} + {{CHUNK{1'b0}}, pc[k]};
            c_d[k] = sl[k][CHUNK];
            s_d[k] = ps[k] | (WIDTH'(sl[k][CHUNK-1:0]) << (k * CHUNK));
        end
    end

    // a^b^s at the top bit recovers the carry into it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q    <= '0;
            c_q    <= '0;
            s_q    <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (adv) begin
            v_q    <= v_d;
            c_q    <= c_d;
            s_q    <= s_d;
            ovf_q  <= pa[L][WIDTH-1] ^ pb[L][WIDTH-1] ^ s_d[L][WIDTH-1] ^ c_d[L];
            zero_q <= ~|s_d[L];
        end
    end

    assign out_valid_o = v_q[L];
    assign sum_o = s_q[L];
    assign c_out_o = c_q[L];
    assign ovf_o = ovf_q;
    assign zero_o = zero_q;
endmodule

// File: tb/tb_pipe_add_sub.sv
// tb_pipe_add_sub: directed vector table, backpressure/reset sequences and a
// parameter sweep, all checked against bench-computed expectations.
module tb_pipe_add_sub;
    logic clk = 1'b0;
    logic rst_n;
    logic in_valid, in_ready, c_in, op_sub, out_valid, out_ready, c_out, ovf, zero;
    logic [31:0] in1, in2, sum;
    int checks = 0;
    int failures = 0;

    logic sw_valid, sw_sub;
    logic [2:0] sw_ci;
    logic [31:0] sw_a, sw_b;
    logic [7:0] s8;
    logic [15:0] s16;
    logic [31:0] s32;
    logic [2:0] sw_v, sw_r, sw_c, sw_o, sw_z;
    logic [31:0] sw_s [3];

    always #5 clk = ~clk;

    pipe_add_sub #(.WIDTH(32), .CHUNK(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in1_i(in1), .in2_i(in2), .c_in_i(c_in), .op_sub_i(op_sub),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .sum_o(sum),
        .c_out_o(c_out), .ovf_o(ovf), .zero_o(zero));

    pipe_add_sub #(.WIDTH(8), .CHUNK(1)) u_w8 (
        .clk(clk), .rst_n(rst_n), .in_valid_i(sw_valid), .in_ready_o(sw_r[0]),
        .in1_i(sw_a[7:0]), .in2_i(sw_b[7:0]), .c_in_i(sw_ci[0]), .op_sub_i(sw_sub),
        .out_valid_o(sw_v[0]), .out_ready_i(1'b1), .sum_o(s8),
        .c_out_o(sw_c[0]), .ovf_o(sw_o[0]), .zero_o(sw_z[0]));

    pipe_add_sub #(.WIDTH(16), .CHUNK(8)) u_w16 (
        .clk(clk), .rst_n(rst_n), .in_valid_i(sw_valid), .in_ready_o(sw_r[1]),
        .in1_i(sw_a[15:0]), .in2_i(sw_b[15:0]), .c_in_i(sw_ci[1]), .op_sub_i(sw_sub),
        .out_valid_o(sw_v[1]), .out_ready_i(1'b1), .sum_o(s16),
        .c_out_o(sw_c[1]), .ovf_o(sw_o[1]), .zero_o(sw_z[1]));

    pipe_add_sub #(.WIDTH(32), .CHUNK(32)) u_w32 (
        .clk(clk), .rst_n(rst_n), .in_valid_i(sw_valid), .in_ready_o(sw_r[2]),
        .in1_i(sw_a), .in2_i(sw_b), .c_in_i(sw_ci[2]), .op_sub_i(sw_sub),
        .out_valid_o(sw_v[2]), .out_ready_i(1'b1), .sum_o(s32),
        .c_out_o(sw_c[2]), .ovf_o(sw_o[2]), .zero_o(sw_z[2]));

    assign sw_s[0] = {24'b0, s8};
    assign sw_s[1] = {16'b0, s16};
    assign sw_s[2] = s32;

    typedef struct packed {
        logic [31:0] s;
        logic c, o, z;
    } res_t;

    typedef struct {
        logic [31:0] a, b;
        logic ci, sub;
        logic [31:0] s;
        logic c, o, z;
    } vec_t;

    function automatic res_t model(input logic [31:0] a, b, input logic ci, sub, input int w);
        logic [32:0] full;
        logic [31:0] m, am, bm;
        res_t r;
        m = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        am = a & m;
        bm = (sub ? ~b : b) & m;
        full = {1'b0, am} + {1'b0, bm} + {32'b0, ci};
        r.s = full[31:0] & m;
        r.c = full[w];
        r.o = (am[w-1] == bm[w-1]) && (r.s[w-1] != am[w-1]);
        r.z = (r.s == 32'd0);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input string nm, input vec_t v);
        int j;
        @(negedge clk);
        chk({nm, "_in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in1 = v.a;
        in2 = v.b;
        c_in = v.ci;
        op_sub = v.sub;
        @(negedge clk);
        in_valid = 1'b0;
        in1 = 32'hDEAD_BEEF;
        in2 = 32'hDEAD_BEEF;
        j = 0;
        while (!out_valid && j < 20) begin
            @(negedge clk);
            j++;
        end
        chk({nm, "_valid_seen"}, 32'(out_valid), 32'd1);
        chk({nm, "_latency"}, 32'(j), 32'd7);
        chk({nm, "_sum"}, sum, v.s);
        chk({nm, "_c_out"}, 32'(c_out), 32'(v.c));
        chk({nm, "_ovf"}, 32'(ovf), 32'(v.o));
        chk({nm, "_zero"}, 32'(zero), 32'(v.z));
        @(negedge clk);
        chk({nm, "_single_pulse"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[11];
        res_t q[$];
        res_t e;
        res_t ex [3];
        logic [31:0] held;
        logic [2:0] seen;
        int cons, issued, cyc, stale;
        int lat_exp [3];
        int wid [3];
        vecs[0]  = '{32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, 32'h0000_0008, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{32'h0000_0007, 32'h0000_0007, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{32'h0000_0005, 32'h0000_0005, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{32'h1234_5678, 32'h0FED_CBA8, 1'b0, 1'b0, 32'h2222_2220, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
        wid = '{8, 16, 32};
        lat_exp = '{7, 1, 0};

        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        in1 = '0;
        in2 = '0;
        c_in = 1'b0;
        op_sub = 1'b0;
        sw_valid = 1'b0;
        sw_a = '0;
        sw_b = '0;
        sw_ci = '0;
        sw_sub = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", sum, 32'd0);
        chk("rst_c_out", 32'(c_out), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_zero", 32'(zero), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 11; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

        // back-to-back beats with a 5-cycle consumer stall
        cons = 0;
        issued = 0;
        cyc = 0;
        held = '0;
        while (cons < 20 && cyc < 100) begin
            @(negedge clk);
            out_ready = !(cyc >= 10 && cyc <= 14);
            in_valid = issued < 20;
            in1 = $urandom;
            in2 = $urandom;
            c_in = 1'($urandom_range(0, 1));
            op_sub = 1'($urandom_range(0, 1));
            #1;
            if (cyc >= 10 && cyc <= 14) begin
                chk($sformatf("stall_in_ready_c%0d", cyc), 32'(in_ready), 32'd0);
                chk($sformatf("stall_valid_c%0d", cyc), 32'(out_valid), 32'd1);
                if (cyc == 10) held = sum;
                else chk($sformatf("stall_hold_c%0d", cyc), sum, held);
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) chk("b2b_extra_result", 32'd1, 32'd0);
                else begin
                    e = q.pop_front();
                    chk($sformatf("b2b_sum%0d", cons), sum, e.s);
                    chk($sformatf("b2b_flags%0d", cons), {29'b0, c_out, ovf, zero}, {29'b0, e.c, e.o, e.z});
                end
                cons++;
            end
            if (in_valid && in_ready) begin
                q.push_back(model(in1, in2, c_in, op_sub, 32));
                issued++;
            end
            cyc++;
        end
        chk("b2b_consumed", 32'(cons), 32'd20);
        chk("b2b_issued", 32'(issued), 32'd20);
        chk("b2b_queue_empty", 32'(q.size()), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;

        // reset with five beats in flight
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in1 = 32'd100 + 32'(i);
            in2 = 32'd1;
            c_in = 1'b0;
            op_sub = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_sum", sum, 32'd0);
        chk("mid_rst_flags", {29'b0, c_out, ovf, zero}, 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        stale = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        chk("mid_rst_no_stale", 32'(stale), 32'd0);
        run_vec("post_rst", vecs[9]);

        // parameter sweep with per-width carry chaining
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            sw_valid = 1'b1;
            sw_a = $urandom;
            sw_b = $urandom;
            sw_sub = 1'($urandom_range(0, 1));
            if (n == 0) begin
                sw_a = 32'hFFFF_FFFF;
                sw_b = 32'h0000_0000;
                sw_sub = 1'b0;
                sw_ci = 3'b111;
            end
            for (int d = 0; d < 3; d++) ex[d] = model(sw_a, sw_b, sw_ci[d], sw_sub, wid[d]);
            @(negedge clk);
            sw_valid = 1'b0;
            seen = '0;
            for (int j = 0; j < 12; j++) begin
                if (j > 0) @(negedge clk);
                for (int d = 0; d < 3; d++) begin
                    if (sw_v[d] && !seen[d]) begin
                        seen[d] = 1'b1;
                        chk($sformatf("sweep_w%0d_b%0d_latency", wid[d], n), 32'(j), 32'(lat_exp[d]));
                        chk($sformatf("sweep_w%0d_b%0d_sum", wid[d], n), sw_s[d], ex[d].s);
                        chk($sformatf("sweep_w%0d_b%0d_flags", wid[d], n), {29'b0, sw_c[d], sw_o[d], sw_z[d]}, {29'b0, ex[d].c, ex[d].o, ex[d].z});
                    end
                end
            end
            chk($sformatf("sweep_b%0d_all_seen", n), 32'(seen), 32'd7);
            for (int d = 0; d < 3; d++) sw_ci[d] = ex[d].c;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
